// File: rtl/eth_link_mon_pkg.sv
// Shared types and constants for the PHY link monitor: FSM state encoding,
// sequence ordered-set codes and the fault hold window.
package eth_link_mon_pkg;

    typedef enum logic [1:0] {
        ST_DOWN      = 2'd0,
        ST_QUALIFY   = 2'd1,
        ST_UP        = 2'd2,
        ST_RESET_REQ = 2'd3
    } link_state_t;

    localparam logic [7:0] SEQ_CODE     = 8'h9C;
    localparam logic [7:0] FAULT_LOCAL  = 8'h01;
    localparam logic [7:0] FAULT_REMOTE = 8'h02;
    localparam int         FAULT_HOLD_CYCLES = 128;

    // Four bytes starting at a lane: 0x9C, 0x00, 0x00, <code>.
    function automatic logic os_match(input logic [31:0] lane_bytes, input logic [7:0] code);
        return (lane_bytes[7:0] == SEQ_CODE) && (lane_bytes[23:8] == 16'h0000) &&
               (lane_bytes[31:24] == code);
    endfunction

endpackage

// File: rtl/link_mon_sat_cnt.sv
// Saturating statistics counter: adds a zero-extended increment each cycle,
// sticks at all-ones, and a clear beats any same-cycle increment.
module link_mon_sat_cnt #(
    parameter int WIDTH     = 32,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [WIDTH-1:0]     count
);

    localparam int SUM_W = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [SUM_W-1:0] sum;

    assign sum = SUM_W'(count_reg) + SUM_W'(inc);

    always_comb begin
        count_next = sum[WIDTH-1:0];
        if (|sum[SUM_W-1:WIDTH]) begin
            count_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/eth_phy_link_mon.sv
// 10G PHY receive link monitor: lock qualification FSM, relock reset request and
// saturating error statistics. Define ETH_LINK_MON_FAULT_DET_EN for XGMII fault detection.
module eth_phy_link_mon
    import eth_link_mon_pkg::*;
#(
    parameter int  CNT_WIDTH        = 32,
    parameter int  QUALIFY_CYCLES   = 1024,
    parameter int  RELOCK_TIMEOUT   = 160000,
    parameter int  RESET_REQ_CYCLES = 16,
    parameter int  DATA_WIDTH       = 64,
    localparam int CTRL_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_block_lock,
    input  logic                  rx_high_ber,
    input  logic                  rx_bad_block,
    input  logic                  rx_sequence_error,
    input  logic [6:0]            rx_error_count,
    input  logic [DATA_WIDTH-1:0] xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
    input  logic                  cnt_clear,
    output logic                  link_up,
    output logic                  rx_reset_req,
    output logic [1:0]            link_state,
    output logic [CNT_WIDTH-1:0]  bad_block_count,
    output logic [CNT_WIDTH-1:0]  seq_err_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  link_down_count,
    output logic                  rx_local_fault,
    output logic                  rx_remote_fault
);

    localparam int TIMER_MAX_A = (RELOCK_TIMEOUT > QUALIFY_CYCLES) ? RELOCK_TIMEOUT : QUALIFY_CYCLES;
    localparam int TIMER_MAX   = (TIMER_MAX_A > RESET_REQ_CYCLES) ? TIMER_MAX_A : RESET_REQ_CYCLES;
    localparam int TIMER_W     = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] RELOCK_LAST    = TIMER_W'(RELOCK_TIMEOUT - 1);
    // The clean cycle seen in DOWN counts as the first of the qualify window.
    localparam logic [TIMER_W-1:0] QUALIFY_LAST   = TIMER_W'(QUALIFY_CYCLES - 2);
    localparam logic [TIMER_W-1:0] RESET_REQ_LAST = TIMER_W'(RESET_REQ_CYCLES - 1);

    link_state_t       state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic              link_up_reg, link_up_next;
    logic              rx_reset_req_reg, rx_reset_req_next;
    logic              link_down_inc;
    logic              clean;

    assign clean = rx_block_lock & ~rx_high_ber;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_DOWN;
            timer_reg        <= '0;
            link_up_reg      <= 1'b0;
            rx_reset_req_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            link_up_reg      <= link_up_next;
            rx_reset_req_reg <= rx_reset_req_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg + TIMER_W'(1);
        case (state_reg)
            ST_DOWN: begin
                if (clean) begin
                    state_next = ST_QUALIFY;
                    timer_next = '0;
                end else if (timer_reg == RELOCK_LAST) begin
                    state_next = ST_RESET_REQ;
                    timer_next = '0;
                end
            end
            ST_QUALIFY: begin
                if (!clean) begin
                    state_next = ST_DOWN;
                    timer_next = '0;
                end else if (timer_reg == QUALIFY_LAST) begin
                    state_next = ST_UP;
                    timer_next = '0;
                end
            end
            ST_UP: begin
                timer_next = '0;
                if (!clean) begin
                    state_next = ST_DOWN;
                end
            end
            ST_RESET_REQ: begin
                if (timer_reg == RESET_REQ_LAST) begin
                    state_next = ST_DOWN;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = ST_DOWN;
                timer_next = '0;
            end
        endcase
    end

    always_comb begin
        link_up_next      = (state_next == ST_UP);
        rx_reset_req_next = (state_next == ST_RESET_REQ);
        link_down_inc     = (state_reg == ST_UP) && !clean;
    end

    assign link_up      = link_up_reg;
    assign rx_reset_req = rx_reset_req_reg;
    assign link_state   = state_reg;

    link_mon_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_bad_block_cnt (
        .clk(clk), .rst(rst), .clear(cnt_clear), .inc(rx_bad_block), .count(bad_block_count)
    );
    link_mon_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_seq_err_cnt (
        .clk(clk), .rst(rst), .clear(cnt_clear), .inc(rx_sequence_error), .count(seq_err_count)
    );
    link_mon_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_WIDTH(7)) u_err_cnt (
        .clk(clk), .rst(rst), .clear(cnt_clear), .inc(rx_error_count), .count(err_count)
    );
    link_mon_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_link_down_cnt (
        .clk(clk), .rst(rst), .clear(cnt_clear), .inc(link_down_inc), .count(link_down_count)
    );

`ifdef ETH_LINK_MON_FAULT_DET_EN
    localparam int LANE_GROUPS = CTRL_WIDTH / 4;

    logic [LANE_GROUPS-1:0] local_hit;
    logic [LANE_GROUPS-1:0] remote_hit;
    logic [1:0]             fault_hit;
    logic [1:0]             fault_flag;
    logic                   unused_rxc;

    // Ordered sets may only start in lane 0 or lane 4 of each 64-bit word.
    for (genvar gi = 0; gi < LANE_GROUPS; gi++) begin : g_lane
        assign local_hit[gi]  = xgmii_rxc[gi*4] & os_match(xgmii_rxd[gi*32 +: 32], FAULT_LOCAL);
        assign remote_hit[gi] = xgmii_rxc[gi*4] & os_match(xgmii_rxd[gi*32 +: 32], FAULT_REMOTE);
    end

    assign fault_hit  = {|remote_hit, |local_hit};
    assign unused_rxc = ^xgmii_rxc;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fault
        logic       flag_reg;
        logic [6:0] age_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                flag_reg <= 1'b0;
                age_reg  <= '0;
            end else if (fault_hit[gi]) begin
                flag_reg <= 1'b1;
                age_reg  <= '0;
            end else if (flag_reg) begin
                if (age_reg == 7'(FAULT_HOLD_CYCLES - 1)) begin
                    flag_reg <= 1'b0;
                end
                age_reg <= age_reg + 7'd1;
            end
        end

        assign fault_flag[gi] = flag_reg;
    end

    assign rx_local_fault  = fault_flag[0];
    assign rx_remote_fault = fault_flag[1];
`else
    logic unused_xgmii;

    assign unused_xgmii    = ^{xgmii_rxd, xgmii_rxc};
    assign rx_local_fault  = 1'b0;
    assign rx_remote_fault = 1'b0;
`endif

endmodule

// File: tb/tb_eth_phy_link_mon.sv
// Testbench for eth_phy_link_mon: directed link scenarios followed by randomized
// stimulus, every cycle checked against a behavioural model of the link rules.
module tb_eth_phy_link_mon;

    localparam int CW     = 8;
    localparam int QUAL   = 1024;
    localparam int RELOCK = 1500;
    localparam int RRC    = 16;
    localparam int DW     = 64;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            lock, ber, bad_blk, seq_err, cnt_clear;
    logic [6:0]      err_inc;
    logic [DW-1:0]   rxd;
    logic [DW/8-1:0] rxc;
    logic            link_up, rx_reset_req, rx_local_fault, rx_remote_fault;
    logic [1:0]      link_state;
    logic [CW-1:0]   bad_block_count, seq_err_count, err_count, link_down_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: state as a small integer, run lengths counted in plain cycles.
    int m_state, m_clean_run, m_down_bad, m_rr_left;
    int m_bad, m_seq, m_err, m_ldc;
    int m_lf_left, m_rf_left;

    eth_phy_link_mon #(
        .CNT_WIDTH(CW), .QUALIFY_CYCLES(QUAL), .RELOCK_TIMEOUT(RELOCK),
        .RESET_REQ_CYCLES(RRC), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_block_lock(lock), .rx_high_ber(ber), .rx_bad_block(bad_blk),
        .rx_sequence_error(seq_err), .rx_error_count(err_inc),
        .xgmii_rxd(rxd), .xgmii_rxc(rxc), .cnt_clear(cnt_clear),
        .link_up(link_up), .rx_reset_req(rx_reset_req), .link_state(link_state),
        .bad_block_count(bad_block_count), .seq_err_count(seq_err_count),
        .err_count(err_count), .link_down_count(link_down_count),
        .rx_local_fault(rx_local_fault), .rx_remote_fault(rx_remote_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic bit os_seen(input logic [DW-1:0] d, input logic [DW/8-1:0] c,
                                   input logic [7:0] code);
        bit hit = 1'b0;
        for (int l = 0; l < DW/8; l += 4) begin
            if (c[l] && d[l*8 +: 8] == 8'h9C && d[l*8+8 +: 16] == 16'h0000 &&
                d[l*8+24 +: 8] == code)
                hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic model_step();
        bit clean = lock && !ber;
        bit drop  = 1'b0;
        if (rst) begin
            m_state = 0; m_clean_run = 0; m_down_bad = 0; m_rr_left = 0;
            m_bad = 0; m_seq = 0; m_err = 0; m_ldc = 0;
            m_lf_left = 0; m_rf_left = 0;
            return;
        end
        case (m_state)
            0: if (clean) begin
                   m_state = 1; m_clean_run = 1;
               end else begin
                   m_down_bad++;
                   if (m_down_bad == RELOCK) begin m_state = 3; m_rr_left = RRC; end
               end
            1: if (!clean) begin
                   m_state = 0; m_down_bad = 0;
               end else begin
                   m_clean_run++;
                   if (m_clean_run == QUAL) m_state = 2;
               end
            2: if (!clean) begin m_state = 0; m_down_bad = 0; drop = 1'b1; end
            default: begin
                m_rr_left--;
                if (m_rr_left == 0) begin m_state = 0; m_down_bad = 0; end
            end
        endcase
        if (cnt_clear) begin
            m_bad = 0; m_seq = 0; m_err = 0; m_ldc = 0;
        end else begin
            m_bad = sat(m_bad + int'(bad_blk));
            m_seq = sat(m_seq + int'(seq_err));
            m_err = sat(m_err + int'(err_inc));
            m_ldc = sat(m_ldc + int'(drop));
        end
`ifdef ETH_LINK_MON_FAULT_DET_EN
        if (os_seen(rxd, rxc, 8'h01)) m_lf_left = 128;
        else if (m_lf_left > 0) m_lf_left--;
        if (os_seen(rxd, rxc, 8'h02)) m_rf_left = 128;
        else if (m_rf_left > 0) m_rf_left--;
`endif
    endtask

    task automatic check_all();
        chk("link_state", link_state, m_state);
        chk("link_up", link_up, m_state == 2);
        chk("rx_reset_req", rx_reset_req, m_state == 3);
        chk("bad_block_count", bad_block_count, m_bad);
        chk("seq_err_count", seq_err_count, m_seq);
        chk("err_count", err_count, m_err);
        chk("link_down_count", link_down_count, m_ldc);
        chk("rx_local_fault", rx_local_fault, m_lf_left > 0);
        chk("rx_remote_fault", rx_remote_fault, m_rf_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        lock = 0; ber = 0; bad_blk = 0; seq_err = 0; cnt_clear = 0;
        err_inc = '0; rxd = '0; rxc = '0;
    endtask

    task automatic pulse_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        int pulses;
        int hi_cnt;
        rst = 1;
        idle_inputs();
        m_state = 0; m_clean_run = 0; m_down_bad = 0; m_rr_left = 0;
        m_bad = 0; m_seq = 0; m_err = 0; m_ldc = 0; m_lf_left = 0; m_rf_left = 0;
        repeat (3) tick();
        chk("reset_state", link_state, 0);
        chk("reset_link_up", link_up, 0);
        rst = 0;
        $display("reset: state=%0d link_up=%0b rr=%0b", link_state, link_up, rx_reset_req);

        // Clean lock for QUAL cycles brings the link up on the following cycle.
        lock = 1;
        for (int i = 1; i <= QUAL; i++) begin
            tick();
            if (i == QUAL - 1) chk("link_up_early", link_up, 0);
        end
        chk("link_up_qualified", link_up, 1);
        $display("qualify: link_up=%0b after %0d clean cycles", link_up, QUAL);

        ber = 1; tick(); ber = 0;
        chk("ber_drop_link_up", link_up, 0);
        chk("ber_drop_count", link_down_count, 1);
        $display("ber pulse: link_up=%0b link_down_count=%0d", link_up, link_down_count);

        // Lock lost at cycle 1000 restarts qualification from scratch.
        pulse_reset();
        lock = 1;
        repeat (999) tick();
        lock = 0; tick();
        chk("drop_1000_state", link_state, 0);
        lock = 1;
        repeat (QUAL - 1) tick();
        chk("requalify_early", link_up, 0);
        tick();
        chk("requalify_up", link_up, 1);
        $display("requalify: link_up=%0b", link_up);

        // Relock timeout and reset-request pulse width.
        pulse_reset();
        lock = 0;
        repeat (RELOCK - 1) tick();
        chk("relock_not_yet", rx_reset_req, 0);
        tick();
        chk("relock_req", rx_reset_req, 1);
        pulses = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rx_reset_req) pulses++;
            else break;
        end
        chk("rr_pulse_len", pulses, RRC);
        chk("rr_after_state", link_state, 0);
        $display("reset request: pulse=%0d cycles, state=%0d", pulses, link_state);

        pulse_reset();
        repeat (RELOCK) tick();
        repeat (4) tick();
        chk("rr_cycle5", rx_reset_req, 1);
        rst = 1; tick(); rst = 0;
        chk("rr_cut_by_rst", rx_reset_req, 0);
        chk("rr_cut_state", link_state, 0);
        $display("reset during request: rr=%0b", rx_reset_req);

        // Saturation and clear priority.
        cnt_clear = 1; tick(); cnt_clear = 0;
        err_inc = 7'd100;
        tick(); chk("err_100", err_count, 100);
        tick(); chk("err_200", err_count, 200);
        tick(); chk("err_sat", err_count, 255);
        err_inc = '0;
        bad_blk = 1; tick();
        cnt_clear = 1; tick();
        chk("clear_wins", bad_block_count, 0);
        cnt_clear = 0; bad_blk = 0;
        $display("counters: err=%0d bad_block=%0d", err_count, bad_block_count);

        // Single remote-fault ordered set in lane 4.
        rxd = {32'h0200_009C, 32'h0707_0707};
        rxc = 8'b0001_0000;
        tick();
        rxd = '0; rxc = '0;
        hi_cnt = int'(rx_remote_fault);
        for (int i = 0; i < 200; i++) begin
            tick();
            hi_cnt += int'(rx_remote_fault);
        end
`ifdef ETH_LINK_MON_FAULT_DET_EN
        chk("remote_fault_cycles", hi_cnt, 128);
`else
        chk("remote_fault_cycles", hi_cnt, 0);
`endif
        $display("remote fault: high for %0d cycles", hi_cnt);

        // Randomized segments: long clean runs, long lock losses, and chatter.
        pulse_reset();
        for (int seg = 0; seg < 30; seg++) begin
            int mode = $urandom_range(0, 2);
            int len  = (mode == 0) ? $urandom_range(1, 1300) :
                       (mode == 1) ? $urandom_range(1, 1700) : $urandom_range(1, 200);
            for (int i = 0; i < len; i++) begin
                case (mode)
                    0: begin lock = 1; ber = 0; end
                    1: begin lock = 0; ber = $urandom_range(0, 1); end
                    default: begin lock = ($urandom_range(0, 3) != 0); ber = ($urandom_range(0, 7) == 0); end
                endcase
                bad_blk   = ($urandom_range(0, 7) == 0);
                seq_err   = ($urandom_range(0, 7) == 0);
                err_inc   = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
                cnt_clear = ($urandom_range(0, 149) == 0);
                rst       = ($urandom_range(0, 2999) == 0);
                rxd = {$urandom, $urandom};
                rxc = 8'($urandom);
                if ($urandom_range(0, 299) == 0) begin
                    int lane = 4 * $urandom_range(0, 1);
                    logic [31:0] os = {($urandom_range(0, 1) != 0) ? 8'h02 : 8'h01, 24'h00009C};
                    rxd[lane*8 +: 32] = os;
                    rxc[lane] = 1'b1;
                end
                tick();
            end
            $display("random segment %0d: mode=%0d len=%0d state=%0d ldc=%0d", seg, mode, len,
                     link_state, link_down_count);
        end
        rst = 0;
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/eth_phy_link_mon.md
ETH_PHY_LINK_MON -- requirements
Module: eth_phy_link_mon

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of each statistics counter.
REQ-002 SHALL have parameter QUALIFY_CYCLES, default 1024, cycles of clean lock before link_up.
REQ-003 SHALL have parameter RELOCK_TIMEOUT, default 160000, cycles without lock before a reset request.
REQ-004 SHALL have parameter RESET_REQ_CYCLES, default 16, width of the reset-request pulse.
REQ-005 SHALL have parameter DATA_WIDTH, default 64, XGMII data width; CTRL_WIDTH = DATA_WIDTH/8.
REQ-006 SHALL have ports: clk in 1 PHY RX clock; rst in 1 reset.
REQ-007 SHALL have ports: rx_block_lock in 1; rx_high_ber in 1; rx_bad_block in 1; rx_sequence_error in 1; rx_error_count in 7 per-cycle error increment.
REQ-008 SHALL have ports: xgmii_rxd in DATA_WIDTH; xgmii_rxc in CTRL_WIDTH; cnt_clear in 1 clears all counters.
REQ-009 SHALL have outputs: link_up 1; rx_reset_req 1; link_state 2 encoded FSM state; bad_block_count, seq_err_count, err_count, link_down_count each CNT_WIDTH; rx_local_fault 1; rx_remote_fault 1.
REQ-010 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-011 FSM states SHALL be DOWN=0, QUALIFY=1, UP=2, RESET_REQ=3, output on link_state.
REQ-012 DOWN: block_lock=1 and high_ber=0 SHALL go to QUALIFY next cycle, clearing the timer; otherwise the timer SHALL increment, and at RELOCK_TIMEOUT-1 go to RESET_REQ.
REQ-013 QUALIFY: block_lock=0 or high_ber=1 SHALL return to DOWN with the timer cleared; after QUALIFY_CYCLES consecutive clean cycles go to UP.
REQ-014 UP: block_lock=0 or high_ber=1 SHALL go to DOWN and increment link_down_count by 1 in the same edge.
REQ-015 RESET_REQ: rx_reset_req SHALL be high for exactly RESET_REQ_CYCLES cycles, then the FSM SHALL go to DOWN with the timer cleared.
REQ-016 link_up SHALL be registered, high exactly while state is UP; rx_reset_req SHALL be high only in RESET_REQ.
REQ-017 bad_block_count and seq_err_count SHALL increment by 1 per cycle the matching input is high; err_count SHALL add rx_error_count zero-extended; all counters SHALL have 1-cycle latency.
REQ-018 All counters SHALL saturate at all-ones, never wrapping; an addition that would overflow SHALL load all-ones.
REQ-019 cnt_clear SHALL zero all counters next cycle; clear SHALL win over a simultaneous increment, dropping that cycle's event; the FSM SHALL be unaffected.
REQ-020 Counters SHALL count in every FSM state.

Reset
REQ-021 rst SHALL force state DOWN, timer 0, link_up 0, rx_reset_req 0, all counters 0, and both fault outputs 0.
REQ-022 rst asserted mid-RESET_REQ SHALL terminate the pulse on the next edge.

Configuration
REQ-023 With macro ETH_LINK_MON_FAULT_DET_EN defined: a sequence ordered set, rxc lane=1 with rxd lane byte 0x9C in lane 0 or 4, and following three bytes 0x00,0x00,0x01 or 0x00,0x00,0x02, SHALL set rx_local_fault or rx_remote_fault respectively.
REQ-024 With the macro defined: each fault flag SHALL clear after 128 consecutive cycles without its ordered set; a new ordered set SHALL restart the 128-cycle window.
REQ-025 Without the macro: rx_local_fault and rx_remote_fault SHALL be constant 0, and xgmii_rxd and xgmii_rxc SHALL be unused.

Structure
REQ-026 Package eth_link_mon_pkg SHALL hold the FSM state enum, the 0x9C sequence code, and the fault code constants.
REQ-027 The saturating counter SHALL be a sub-module, link_mon_sat_cnt, instantiated four times.

Verification
REQ-028 Lock high, high_ber low for 1024 cycles -> link_up rises on cycle 1025; a lock drop at cycle 1000 -> stays DOWN, timer restarts.
REQ-029 Lock held low 160000 cycles -> rx_reset_req high for exactly 16 cycles, then state DOWN; rst asserted on pulse cycle 5 -> rx_reset_req low next edge.
REQ-030 UP, then high_ber pulsed for 1 cycle -> link_up falls next cycle, link_down_count=1.
REQ-031 CNT_WIDTH=8, rx_error_count=100 for 3 cycles -> err_count=100, 200, 255 (saturated); cnt_clear while bad_block high -> bad_block_count=0.
REQ-032 Macro on: lane-4 ordered set 0x9C,0x00,0x00,0x02 once -> rx_remote_fault=1 for 128 cycles, then 0; macro off -> fault outputs stay 0.
